// File: rtl/simon_sequence_player.sv
// rtl/simon_sequence_player.sv - plays a stored Simon colour sequence on four LEDs, paced by 1 Hz ticks
module simon_sequence_player #(
  parameter int MAX_LEN   = 16,
  parameter int ON_TICKS  = 1,
  parameter int OFF_TICKS = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         tick,
  input  logic                         start,
  input  logic [$clog2(MAX_LEN+1)-1:0] length,
  input  logic [1:0]                   seq_color,
  output logic [$clog2(MAX_LEN)-1:0]   seq_addr,
  output logic [3:0]                   led,
  output logic                         busy,
  output logic                         done
);

  localparam int AW   = $clog2(MAX_LEN);
  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, ON, OFF, FINISH} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   step, step_n;
  logic [LW-1:0]   len_reg, len_n;
  logic [TW-1:0]   tcnt, tcnt_n, tcnt_inc;
  logic [1:0]      color_reg, color_n;
  logic            last_reg, last_n;
  logic            at_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      step      <= '0;
      len_reg   <= '0;
      tcnt      <= '0;
      color_reg <= '0;
      last_reg  <= 1'b0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      len_reg   <= len_n;
      tcnt      <= tcnt_n;
      color_reg <= color_n;
      last_reg  <= last_n;
    end
  end

  // last_reg remembers that the final step has been lit, since step holds at len-1
  // both while that step is lit and during the gap before it.
  always_comb begin
    state_n  = state;
    step_n   = step;
    len_n    = len_reg;
    tcnt_n   = tcnt;
    color_n  = color_reg;
    last_n   = last_reg;
    tcnt_inc = tcnt + TW'(1);
    at_last  = (LW'(step) == (len_reg - LW'(1)));

    case (state)
      IDLE: begin
        step_n = '0;
        if (start) begin
          len_n  = (length > LW'(MAX_LEN)) ? LW'(MAX_LEN) : length;
          last_n = 1'b0;
          tcnt_n = '0;
          if (len_n == '0) begin
            state_n = FINISH;
          end else begin
            color_n = seq_color;
            state_n = ON;
          end
        end
      end
      ON: begin
        if (tick) begin
          if (tcnt_inc == TW'(ON_TICKS)) begin
            tcnt_n  = '0;
            state_n = OFF;
            if (at_last) last_n = 1'b1;
            else         step_n = step + AW'(1);
          end else begin
            tcnt_n = tcnt_inc;
          end
        end
      end
      OFF: begin
        if (tick) begin
          if (tcnt_inc == TW'(OFF_TICKS)) begin
            tcnt_n = '0;
            if (last_reg) begin
              state_n = FINISH;
            end else begin
              color_n = seq_color;
              state_n = ON;
            end
          end else begin
            tcnt_n = tcnt_inc;
          end
        end
      end
      FINISH: begin
        step_n  = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    led = '0;
    if (state == ON) led = 4'(1) << color_reg;
  end

  assign seq_addr = step;
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);

endmodule
